// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: one command per handshake, one pixel per clock.
// Handles fill, outline, clear and full-screen fill, with edge clipping.
module rect_fill_engine #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int SIZE_W          = 8,
  parameter int COLOUR_W        = 3
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [1:0]          iMode,
  input  logic [X_W-1:0]      iX,
  input  logic [Y_W-1:0]      iY,
  input  logic [SIZE_W-1:0]   iW,
  input  logic [SIZE_W-1:0]   iH,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic                iAbort,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oReady,
  output logic                oDone
);

  localparam int XS_W = ((X_W > SIZE_W) ? X_W : SIZE_W) + 1;
  localparam int YS_W = ((Y_W > SIZE_W) ? Y_W : SIZE_W) + 1;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t state_q, state_d;

  logic [1:0]          mode_q, mode_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [SIZE_W-1:0]   w_q, w_d;
  logic [SIZE_W-1:0]   h_q, h_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic [SIZE_W-1:0]   dx_q, dx_d;
  logic [SIZE_W-1:0]   dy_q, dy_d;

  logic [X_W-1:0]      ox_d;
  logic [Y_W-1:0]      oy_d;
  logic [COLOUR_W-1:0] ocol_d;
  logic                plot_d;
  logic                ready_d;
  logic                done_d;

  logic                full;
  logic [X_W-1:0]      e_x;
  logic [Y_W-1:0]      e_y;
  logic [SIZE_W-1:0]   e_w;
  logic [SIZE_W-1:0]   e_h;
  logic [COLOUR_W-1:0] e_col;

  logic                drawing;
  logic [1:0]          s_mode;
  logic [X_W-1:0]      s_x;
  logic [Y_W-1:0]      s_y;
  logic [SIZE_W-1:0]   s_w;
  logic [SIZE_W-1:0]   s_h;
  logic                row_end;
  logic                last;
  logic [SIZE_W-1:0]   n_dx;
  logic [SIZE_W-1:0]   n_dy;
  logic [XS_W-1:0]     sum_x;
  logic [YS_W-1:0]     sum_y;
  logic                on_edge;
  logic                vis;

  // Screen-wide modes override the geometry; clear also forces black.
  assign full  = iMode[1];
  assign e_x   = full ? '0 : iX;
  assign e_y   = full ? '0 : iY;
  assign e_w   = full ? SIZE_W'(X_SCREEN_PIXELS) : iW;
  assign e_h   = full ? SIZE_W'(Y_SCREEN_PIXELS) : iH;
  assign e_col = (iMode == 2'b10) ? '0 : iColour;

  // Outputs are registered, so evaluate the pixel about to be presented:
  // the origin on accept, otherwise the raster successor of (dx,dy).
  assign drawing = (state_q == DRAW);
  assign s_mode  = drawing ? mode_q : iMode;
  assign s_x     = drawing ? x_q : e_x;
  assign s_y     = drawing ? y_q : e_y;
  assign s_w     = drawing ? w_q : e_w;
  assign s_h     = drawing ? h_q : e_h;

  assign row_end = (dx_q == w_q - SIZE_W'(1));
  assign last    = row_end && (dy_q == h_q - SIZE_W'(1));
  assign n_dx    = (drawing && !row_end) ? dx_q + SIZE_W'(1) : '0;
  assign n_dy    = !drawing ? '0 :
                   row_end  ? dy_q + SIZE_W'(1) : dy_q;

  assign sum_x   = XS_W'(s_x) + XS_W'(n_dx);
  assign sum_y   = YS_W'(s_y) + YS_W'(n_dy);
  assign on_edge = (n_dx == '0) || (n_dx == s_w - SIZE_W'(1)) ||
                   (n_dy == '0) || (n_dy == s_h - SIZE_W'(1));
  assign vis     = (sum_x < XS_W'(X_SCREEN_PIXELS)) &&
                   (sum_y < YS_W'(Y_SCREEN_PIXELS)) &&
                   ((s_mode != 2'b01) || on_edge);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ox_d    = oX;
    oy_d    = oY;
    ocol_d  = oColour;
    plot_d  = 1'b0;
    ready_d = oReady;
    done_d  = oDone;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (iStart) begin
          mode_d = iMode;
          x_d    = e_x;
          y_d    = e_y;
          w_d    = e_w;
          h_d    = e_h;
          col_d  = e_col;
          done_d = 1'b0;
          if (e_w == '0 || e_h == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = DRAW;
            ready_d = 1'b0;
            dx_d    = '0;
            dy_d    = '0;
            ox_d    = sum_x[X_W-1:0];
            oy_d    = sum_y[Y_W-1:0];
            ocol_d  = e_col;
            plot_d  = vis;
          end
        end
      end
      DRAW: begin
        if (iAbort) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (last) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          dx_d   = n_dx;
          dy_d   = n_dy;
          ox_d   = sum_x[X_W-1:0];
          oy_d   = sum_y[Y_W-1:0];
          ocol_d = col_q;
          plot_d = vis;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
      oReady  <= 1'b1;
      oDone   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      oX      <= ox_d;
      oY      <= oy_d;
      oColour <= ocol_d;
      oPlot   <= plot_d;
      oReady  <= ready_d;
      oDone   <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: table vectors, hand sequences and
// random commands checked against a raster reference model.
module tb_rect_fill_engine;

  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic       iStart = 1'b0;
  logic [1:0] iMode = '0;
  logic [7:0] iX = '0;
  logic [6:0] iY = '0;
  logic [7:0] iW = '0;
  logic [7:0] iH = '0;
  logic [2:0] iColour = '0;
  logic       iAbort = 1'b0;
  logic [7:0] oX;
  logic [6:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oReady;
  logic       oDone;

  rect_fill_engine dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart),
    .iMode(iMode), .iX(iX), .iY(iY), .iW(iW), .iH(iH),
    .iColour(iColour), .iAbort(iAbort),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .oReady(oReady), .oDone(oDone)
  );

  always #5 iClock = ~iClock;

  int n_tests = 0;
  int n_fail  = 0;

  // effective command as the model sees it
  int em, ex, ey, ew, eh, ec;

  typedef struct {
    string name;
    int m, x, y, w, h, c;
    int plots, cyc;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input bit ok,
                       input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_eff(input int m, x, y, w, h, c);
    em = m;
    ex = (m >= 2) ? 0 : x;
    ey = (m >= 2) ? 0 : y;
    ew = (m >= 2) ? 160 : w;
    eh = (m >= 2) ? 120 : h;
    ec = (m == 2) ? 0 : c;
  endtask

  function automatic bit exp_plot(input int dx, input int dy);
    bit inside_scr, border;
    inside_scr = (ex + dx < 160) && (ey + dy < 120);
    border = (dx == 0) || (dx == ew - 1) || (dy == 0) || (dy == eh - 1);
    return inside_scr && (em != 1 || border);
  endfunction

  function automatic int model_plots();
    int n = 0;
    for (int dy = 0; dy < eh; dy++)
      for (int dx = 0; dx < ew; dx++)
        if (exp_plot(dx, dy)) n++;
    return n;
  endfunction

  // caller sits at a negedge; start is presented in that cycle
  task automatic start_cmd(input int m, x, y, w, h, c, input bit ab);
    set_eff(m, x, y, w, h, c);
    iMode = 2'(m);
    iX = 8'(x);
    iY = 7'(y);
    iW = 8'(w);
    iH = 8'(h);
    iColour = 3'(c);
    iAbort = ab;
    iStart = 1'b1;
    @(posedge iClock);
    #1;
    iStart = 1'b0;
    iAbort = 1'b0;
  endtask

  task automatic pix_cmp(input int idx, inout int errs);
    int dx, dy;
    bit ok;
    dx = idx % ew;
    dy = idx / ew;
    ok = (oX == 8'(ex + dx)) && (oY == 7'(ey + dy)) &&
         (oColour == 3'(ec)) && (oPlot == exp_plot(dx, dy)) &&
         !oReady && !oDone;
    if (!ok) begin
      errs++;
      if (errs <= 3)
        $display("  pixel %0d dx=%0d dy=%0d: x=%0d y=%0d c=%0d p=%0b r=%0b d=%0b, want x=%0d y=%0d c=%0d p=%0b",
                 idx, dx, dy, oX, oY, oColour, oPlot, oReady, oDone,
                 8'(ex + dx), 7'(ey + dy), ec, exp_plot(dx, dy));
    end
  endtask

  // Follows a whole command; leaves the caller at the first IDLE negedge.
  task automatic watch(input string name, input int exp_cyc,
                       input int exp_plots, input bit poke);
    int idx = 0;
    int plots = 0;
    int errs = 0;
    int budget = exp_cyc + 8;
    @(negedge iClock);
    while (!oReady && idx < budget) begin
      pix_cmp(idx, errs);
      if (oPlot) plots++;
      if (poke && idx == 2) begin
        iMode = 2'b00;
        iX = 8'd50;
        iY = 7'd5;
        iW = 8'd1;
        iH = 8'd1;
        iStart = 1'b1;
      end
      if (poke && idx == 3) iStart = 1'b0;
      idx++;
      @(negedge iClock);
    end
    iStart = 1'b0;
    check({name, " stream"}, errs == 0, errs, 0);
    check({name, " cycles"}, idx == exp_cyc, idx, exp_cyc);
    check({name, " plots"}, plots == exp_plots, plots, exp_plots);
    check({name, " done"}, oDone && oReady && !oPlot,
          {oDone, oReady, oPlot}, 3'b110);
  endtask

  initial begin
    int errs;
    tbl[0] = '{"fill4x4",   0, 10, 20, 4, 4, 2, 16, 16};
    tbl[1] = '{"outline",   1, 0, 0, 5, 3, 6, 12, 15};
    tbl[2] = '{"clip",      0, 158, 118, 4, 4, 7, 4, 16};
    tbl[3] = '{"clear",     2, 33, 44, 9, 9, 5, 19200, 19200};
    tbl[4] = '{"fillscr",   3, 1, 1, 2, 2, 4, 19200, 19200};
    tbl[5] = '{"zero_w",    0, 3, 3, 0, 7, 1, 0, 0};
    tbl[6] = '{"one_px",    1, 5, 5, 1, 1, 3, 1, 1};

    repeat (3) @(posedge iClock);
    @(negedge iClock);
    check("reset outputs",
          {oX, oY, oColour, oPlot, oReady, oDone} == {20'd0, 2'b10},
          {oX, oY, oColour, oPlot, oReady, oDone}, {20'd0, 2'b10});
    iReset = 1'b0;
    @(negedge iClock);

    // back-to-back: each start lands in the first IDLE cycle
    foreach (tbl[i]) begin
      start_cmd(tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h,
                tbl[i].c, 1'b0);
      watch(tbl[i].name, tbl[i].cyc, tbl[i].plots, 1'b0);
    end

    start_cmd(0, 10, 20, 4, 4, 2, 1'b0);
    watch("start_in_draw", 16, 16, 1'b1);

    start_cmd(0, 10, 20, 4, 4, 2, 1'b1);
    watch("abort_with_start", 16, 16, 1'b0);

    // abort after five pixels
    start_cmd(0, 10, 20, 4, 4, 2, 1'b0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClock);
      pix_cmp(i, errs);
    end
    iAbort = 1'b1;
    @(negedge iClock);
    iAbort = 1'b0;
    check("abort pixels", errs == 0, errs, 0);
    check("abort idle", oReady && !oPlot && !oDone,
          {oReady, oPlot, oDone}, 3'b100);

    // reset in the middle of a draw
    start_cmd(0, 10, 20, 4, 4, 2, 1'b0);
    repeat (3) @(negedge iClock);
    iReset = 1'b1;
    @(negedge iClock);
    check("reset mid-draw",
          {oX, oY, oColour, oPlot, oReady, oDone} == {20'd0, 2'b10},
          {oX, oY, oColour, oPlot, oReady, oDone}, {20'd0, 2'b10});
    iReset = 1'b0;
    @(negedge iClock);

    for (int i = 0; i < 25; i++) begin
      int m, x, y, w, h, c;
      m = (i == 12) ? 3 : int'($urandom_range(0, 1));
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 127);
      w = $urandom_range(0, 20);
      h = $urandom_range(0, 20);
      c = $urandom_range(0, 7);
      if (x > 100 && (i % 3) != 0) x = x % 170;
      if (y > 60 && (i % 3) != 0) y = y % 125;
      start_cmd(m, x, y, w, h, c, 1'b0);
      watch($sformatf("rand%0d", i), ew * eh, model_plots(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
